// File: rtl/mdu_pkg.sv
// Shared MDU constants for the E stage.
//   - MDU_* : 4-bit MDUOp codes decoded by the control unit
//   - mdu_state_e : multiply/divide sequencer states
//   - MDU_CNT_W : width of the busy-cycle counter
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int MDU_CNT_W = 16;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage MDU bus.
//   master (control/datapath side): drives start, MDUOp, A, B; reads busy, HI, LO, MDUOut
//   slave  (mdu):                   the reverse
interface mdu_if;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (output start, MDUOp, A, B,
                    input  busy, HI, LO, MDUOut);
    modport slave  (input  start, MDUOp, A, B,
                    output busy, HI, LO, MDUOut);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO.
//   clk   : core clock, rising edge
//   reset : synchronous active-low clear
//   bus   : mdu_if.slave -- start/MDUOp/A/B in, busy/HI/LO/MDUOut out
// The result is computed behaviourally at the start edge and held internally;
// the counter only models latency. HI/LO commit on the last busy edge.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam logic [MDU_CNT_W-1:0] MUL_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_CNT = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            hi_q, hi_d;
    logic [31:0]            lo_q, lo_d;
    logic [31:0]            res_hi_q, res_hi_d;
    logic [31:0]            res_lo_q, res_lo_d;
    logic                   dz_q, dz_d;

    // Arithmetic on the current operands.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] div_a_s, div_b_s, quo_s, rem_s;
    logic        [31:0] div_b_u, quo_u, rem_u;

    always_comb begin
        prod_s  = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
        // 33-bit signed divide so that 0x80000000 / -1 cannot overflow the
        // operator; divisor forced to 1 on zero to keep the math defined
        // (the result is discarded in that case anyway).
        div_a_s = {bus.A[31], bus.A};
        div_b_s = (bus.B == 32'd0) ? 33'sd1 : {bus.B[31], bus.B};
        quo_s   = div_a_s / div_b_s;
        rem_s   = div_a_s % div_b_s;
        div_b_u = (bus.B == 32'd0) ? 32'd1 : bus.B;
        quo_u   = bus.A / div_b_u;
        rem_u   = bus.A % div_b_u;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_mul(bus.MDUOp)) begin
                    state_d = ST_MUL;
                    cnt_d   = MUL_CNT;
                    dz_d    = 1'b0;
                    if (bus.MDUOp == MDU_MULT) begin
                        res_hi_d = prod_s[63:32];
                        res_lo_d = prod_s[31:0];
                    end else begin
                        res_hi_d = prod_u[63:32];
                        res_lo_d = prod_u[31:0];
                    end
                end else if (bus.start && is_div(bus.MDUOp)) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_CNT;
                    dz_d    = (bus.B == 32'd0);
                    if (bus.MDUOp == MDU_DIV) begin
                        res_hi_d = rem_s[31:0];
                        res_lo_d = quo_s[31:0];
                    end else begin
                        res_hi_d = rem_u;
                        res_lo_d = quo_u;
                    end
                end else if (!bus.start) begin
                    // A start with a non-mult/div op is a no-op, so moves
                    // only happen on a quiet cycle.
                    if (bus.MDUOp == MDU_MTHI) hi_d = bus.A;
                    if (bus.MDUOp == MDU_MTLO) lo_d = bus.A;
                end
            end
            ST_MUL, ST_DIV: begin
                // start/MT* are ignored here; only the counter advances.
                if (cnt_q == MDU_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    always_comb begin
        case (bus.MDUOp)
            MDU_MFHI: bus.MDUOut = hi_q;
            MDU_MFLO: bus.MDUOut = lo_q;
            default:  bus.MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: each mult/div pushes its expected HI/LO and busy
// length; the entry is popped and compared when busy drops.
module tb_mdu;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive a start pulse for one edge; returns at the negedge of busy cycle 1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_NONE;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic mv(input logic [3:0] op, input logic [31:0] a);
        bus.MDUOp = op;
        bus.A     = a;
        @(negedge clk);
        bus.MDUOp = MDU_NONE;
    endtask

    // Count busy cycles (bounded); optionally inject a stray start at busy
    // cycle inj and an MTLO at inj+1, checking LO is untouched after it.
    task automatic wait_done(input int inj, input logic [31:0] mid_lo);
        int   n;
        exp_t e;
        n = 0;
        while (bus.busy && n < 60) begin
            n++;
            if (inj > 0 && n == inj) begin
                bus.start = 1'b1; bus.MDUOp = MDU_MULTU; bus.A = 32'd3; bus.B = 32'd3;
            end else if (inj > 0 && n == inj + 1) begin
                bus.start = 1'b0; bus.MDUOp = MDU_MTLO; bus.A = 32'h55;
            end else if (inj > 0 && n == inj + 2) begin
                bus.MDUOp = MDU_NONE;
                chk("mtlo_busy", bus.LO, mid_lo);
            end
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_cyc"}, 32'(n), 32'(e.cyc));
            chk({e.tag, "_hi"}, bus.HI, e.hi);
            chk({e.tag, "_lo"}, bus.LO, e.lo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] rp;
        bus.start = 1'b0;
        bus.MDUOp = MDU_NONE;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_out", bus.MDUOut, 32'd0);

        // MULTU max * 2
        sb.push_back('{"multu", 32'h1, 32'hFFFF_FFFE, 5});
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(0, 0);
        bus.MDUOp = MDU_MFHI; #1;
        chk("mfhi", bus.MDUOut, 32'h1);
        bus.MDUOp = MDU_NONE;
        @(negedge clk);

        // Signed multiply and divide
        sb.push_back('{"mult", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5});
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd4);
        wait_done(0, 0);
        sb.push_back('{"div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 0);
        sb.push_back('{"div_pos_neg", 32'd1, 32'hFFFF_FFFE, 10});
        issue(MDU_DIV, 32'd7, 32'hFFFF_FFFD);
        wait_done(0, 0);

        // Divide by zero keeps HI/LO
        mv(MDU_MTHI, 32'h11);
        mv(MDU_MTLO, 32'h22);
        chk("mthi11", bus.HI, 32'h11);
        chk("mtlo22", bus.LO, 32'h22);
        sb.push_back('{"divu0", 32'h11, 32'h22, 10});
        issue(MDU_DIVU, 32'd7, 32'd0);
        wait_done(0, 0);

        // Stray start and MTLO while busy
        sb.push_back('{"divu_inj", 32'd2, 32'd14, 10});
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done(3, 32'h22);
        @(negedge clk);
        chk("no_restart", 32'(bus.busy), 32'd0);

        // Moves and reads while idle
        mv(MDU_MTHI, 32'hABCD_1234);
        chk("mthi", bus.HI, 32'hABCD_1234);
        bus.MDUOp = MDU_MFLO; #1;
        chk("mflo", bus.MDUOut, 32'd14);
        bus.MDUOp = MDU_NONE; #1;
        chk("none_out", bus.MDUOut, 32'd0);
        @(negedge clk);

        // start with a non-mult/div op is ignored
        bus.start = 1'b1; bus.MDUOp = MDU_MTLO; bus.A = 32'h99;
        @(negedge clk);
        bus.start = 1'b0; bus.MDUOp = MDU_NONE;
        chk("start_mt_busy", 32'(bus.busy), 32'd0);
        chk("start_mt_lo", bus.LO, 32'd14);

        // Reset mid-multiply
        issue(MDU_MULT, 32'd5, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst2_busy", 32'(bus.busy), 32'd0);
        chk("rst2_hi", bus.HI, 32'd0);
        chk("rst2_lo", bus.LO, 32'd0);
        @(negedge clk);
        chk("rst2_hold", bus.LO, 32'd0);
        sb.push_back('{"multu67", 32'd0, 32'd42, 5});
        issue(MDU_MULTU, 32'd6, 32'd7);
        wait_done(0, 0);

        // Random unsigned traffic
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                rp = 64'(ra) * 64'(rb);
                sb.push_back('{"rmultu", rp[63:32], rp[31:0], 5});
                issue(MDU_MULTU, ra, rb);
            end else begin
                rb = rb >> (i * 4);
                rb = rb | 32'd1;
                sb.push_back('{"rdivu", ra % rb, ra / rb, 10});
                issue(MDU_DIVU, ra, rb);
            end
            wait_done(0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core.
- Sits in the E stage, next to the ALU, directly downstream of the control unit. It consumes the MDU op code and start pulse decoded there, plus the E-stage operands.
- Owns the HI/LO registers and reports busy, so the hazard unit can stall later mult/div/mf/mt instructions in D.
- Result of mfhi/mflo goes to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous active-low reset: 0 at a rising edge clears the unit
- start  input  1  one-cycle pulse from CU, asserted with a mult/multu/div/divu op in E
- MDUOp  input  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  computation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- MDUOut  output  32  read data: HI for MFHI, LO for MFLO, otherwise 0 (combinational)

Behaviour:
- Reset, at a rising edge with reset==0, regardless of state:
  - HI=0, LO=0, busy=0, state=IDLE, counter=0.
  - An in-flight operation is discarded.
- States:
  - IDLE: accepts new work.
  - MUL: counting a multiply.
  - DIV: counting a divide.
- IDLE, start=1 with MULT/MULTU at edge T:
  - Latch the product into internal result registers and load counter=MULT_CYCLES.
  - Go to MUL; busy=1 from cycle T+1.
- IDLE, start=1 with DIV/DIVU: same as above with DIV_CYCLES, going to DIV.
- Result latching:
  - Product is 64 bits: signed for MULT, unsigned for MULTU. Result hi half goes to HI, lo half to LO.
  - Divide: LO=quotient, HI=remainder. DIV is signed, truncating toward zero, remainder takes the sign of the dividend. DIVU is unsigned.
- MUL/DIV: counter decrements each edge.
  - At the edge where counter==1: HI/LO take the latched result, state returns to IDLE, busy=0 next cycle.
  - busy is therefore high for exactly N cycles (T+1 .. T+N); new HI/LO are visible from cycle T+N+1.
- Divide by zero (B==0): the unit still goes busy for DIV_CYCLES, but HI/LO stay unchanged at completion.
- start while busy: ignored.
  - The hazard unit guarantees no start while busy. The RTL still must not restart or corrupt the result.
- MTHI/MTLO:
  - Only when IDLE (busy==0 and start==0): HI (or LO) takes A at the edge.
  - Ignored while busy.
- MFHI/MFLO: MDUOut reflects the current register value combinationally. During busy it returns the old value; the hazard unit prevents such reads.
- start=1 with a non-mult/div MDUOp: ignored, stays IDLE.
- Stall condition exported to the hazard unit is (start | busy). The block provides both signals; the OR is formed outside.
- Latched operands/result are internal. A and B may change after the start edge without effect.

Decomposition:
- Shared constant header, alongside the NPC/ALU/DM codes: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO as 4-bit defines.
- The state encodings also go in that header.
- No sub-module. Arithmetic uses behavioural operators (*, /, %) on sign-extended/zero-extended operands; the cycle count is modelled by the counter only.

Test Plan:
- MULTU A=0xFFFFFFFF, B=2, start pulse → busy high exactly 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE, MFHI gives 0x00000001.
- MULT A=0xFFFFFFFD (-3), B=4 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFF4. DIV A=0xFFFFFFF9 (-7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 after MTHI 0x11 and MTLO 0x22 → busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- DIVU 100/7 started; in busy cycle 3 assert start MULTU 3*3 and MTLO 0x55 → both ignored; final LO=14, HI=2, busy low after exactly 10 cycles.
- MULT in flight; reset=0 in busy cycle 2 → next cycle busy=0, HI=LO=0. A later MULTU 6*7 completes normally with LO=42.
- MTHI A=0xABCD1234 while idle → HI=0xABCD1234 next cycle. MDUOp=MFLO gives LO; MDUOp=NONE gives MDUOut=0.
